// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller_pkg
//  Description : Shared types and constants for the multicycle controller:
//                FSM state enum, ALUControl codes, condition codes, the
//                instruction op field encodings and data-processing cmds.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    // ALUControl output codes
    localparam logic [3:0] C_ALU_ADD = 4'b0000;
    localparam logic [3:0] C_ALU_SUB = 4'b0001;
    localparam logic [3:0] C_ALU_AND = 4'b0010;
    localparam logic [3:0] C_ALU_ORR = 4'b0011;
    localparam logic [3:0] C_ALU_EOR = 4'b0100;
    localparam logic [3:0] C_ALU_MOV = 4'b0101;

    // Data-processing cmd field (funct[4:1])
    localparam logic [3:0] C_CMD_AND = 4'b0000;
    localparam logic [3:0] C_CMD_EOR = 4'b0001;
    localparam logic [3:0] C_CMD_SUB = 4'b0010;
    localparam logic [3:0] C_CMD_ADD = 4'b0100;
    localparam logic [3:0] C_CMD_CMP = 4'b1010;
    localparam logic [3:0] C_CMD_ORR = 4'b1100;
    localparam logic [3:0] C_CMD_MOV = 4'b1101;

    // Instruction op field
    localparam logic [1:0] C_OP_DP   = 2'b00;
    localparam logic [1:0] C_OP_MEM  = 2'b01;
    localparam logic [1:0] C_OP_BR   = 2'b10;
    localparam logic [1:0] C_OP_NONE = 2'b11;

    // Condition codes
    localparam logic [3:0] C_COND_EQ = 4'b0000;
    localparam logic [3:0] C_COND_NE = 4'b0001;
    localparam logic [3:0] C_COND_CS = 4'b0010;
    localparam logic [3:0] C_COND_CC = 4'b0011;
    localparam logic [3:0] C_COND_MI = 4'b0100;
    localparam logic [3:0] C_COND_PL = 4'b0101;
    localparam logic [3:0] C_COND_VS = 4'b0110;
    localparam logic [3:0] C_COND_VC = 4'b0111;
    localparam logic [3:0] C_COND_HI = 4'b1000;
    localparam logic [3:0] C_COND_LS = 4'b1001;
    localparam logic [3:0] C_COND_GE = 4'b1010;
    localparam logic [3:0] C_COND_LT = 4'b1011;
    localparam logic [3:0] C_COND_GT = 4'b1100;
    localparam logic [3:0] C_COND_LE = 4'b1101;
    localparam logic [3:0] C_COND_AL = 4'b1110;

endpackage : multicycle_controller_pkg
`default_nettype wire

// File: rtl/multicycle_controller_cond_check.sv
`default_nettype none
// ============================================================================
//  Module      : cond_check
//  Description : NZCV flags register plus condition evaluation. CondEx is a
//                pure function of the cond field and the stored flags.
//  Ports       : clk, reset (sync, active-low)
//                i_cond[3:0]      instruction condition field
//                i_alu_flags[3:0] NZCV from the ALU this cycle
//                i_wr_nz, i_wr_cv write enables for N,Z and C,V
//                o_cond_ex        condition passes
//                o_flags[3:0]     stored NZCV
//  Revision    : 1.0 - initial release
// ============================================================================
module cond_check
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic       i_wr_nz,
    input  logic       i_wr_cv,
    output logic       o_cond_ex,
    output logic [3:0] o_flags
);

    logic [3:0] r_flags;
    logic       w_n, w_z, w_c, w_v;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else begin
            if (i_wr_nz) r_flags[3:2] <= i_alu_flags[3:2];
            if (i_wr_cv) r_flags[1:0] <= i_alu_flags[1:0];
        end
    end

    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign o_flags = r_flags;

    always_comb begin
        o_cond_ex = 1'b0;
        case (i_cond)
            C_COND_EQ: o_cond_ex = w_z;
            C_COND_NE: o_cond_ex = ~w_z;
            C_COND_CS: o_cond_ex = w_c;
            C_COND_CC: o_cond_ex = ~w_c;
            C_COND_MI: o_cond_ex = w_n;
            C_COND_PL: o_cond_ex = ~w_n;
            C_COND_VS: o_cond_ex = w_v;
            C_COND_VC: o_cond_ex = ~w_v;
            C_COND_HI: o_cond_ex = w_c & ~w_z;
            C_COND_LS: o_cond_ex = ~w_c | w_z;
            C_COND_GE: o_cond_ex = (w_n == w_v);
            C_COND_LT: o_cond_ex = (w_n != w_v);
            C_COND_GT: o_cond_ex = ~w_z & (w_n == w_v);
            C_COND_LE: o_cond_ex = w_z | (w_n != w_v);
            C_COND_AL: o_cond_ex = 1'b1;
            default:   o_cond_ex = 1'b0;   // 1111 never executes
        endcase
    end

endmodule : cond_check
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_controller
//  Description : Multicycle ARM-subset control unit: main FSM, per-state
//                datapath control decode and ALU decode. Flags and
//                condition evaluation live in cond_check.
//  Ports       : clk, reset (sync, active-low)
//                Instr[19:0]    instruction bits [31:12]
//                ALUFlags[3:0]  NZCV from ALU
//                mem_ready      memory access complete
//                PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA
//                ResultSrc, ALUSrcB, ImmSrc, RegSrc (2 bits each)
//                ALUControl[3:0], state_o[3:0] (debug)
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MEM_STALL = 1
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [3:0]  ALUControl,
    output logic [3:0]  state_o
);

    state_t     r_state, w_next;
    logic       w_mem_ready;
    logic [3:0] w_cond, w_cmd, w_rd;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic       w_cond_ex, w_rd_pc;
    logic [3:0] w_flags;
    logic       w_unused;

    // ALU decode results
    logic [3:0] w_dp_ctl;
    logic       w_cmd_ok, w_cmd_arith, w_nowrite;

    // Unmasked control values, strobes are gated by reset below
    logic       w_pcwrite, w_irwrite, w_regwrite, w_memwrite;
    logic       w_flag_nz, w_flag_cv;

    assign w_cond   = Instr[19:16];
    assign w_op     = Instr[15:14];
    assign w_funct  = Instr[13:8];
    assign w_rd     = Instr[3:0];
    assign w_cmd    = w_funct[4:1];
    assign w_rd_pc  = (w_rd == 4'hF);
    assign w_unused = &{1'b0, Instr[7:4]};

    assign w_mem_ready = (MEM_STALL != 0) ? mem_ready : 1'b1;

    // ------------------------------------------------------------------
    // ALU decode of the data-processing cmd field
    // ------------------------------------------------------------------
    always_comb begin
        w_dp_ctl    = C_ALU_ADD;
        w_cmd_ok    = 1'b1;
        w_cmd_arith = 1'b0;
        w_nowrite   = 1'b0;
        case (w_cmd)
            C_CMD_ADD: begin w_dp_ctl = C_ALU_ADD; w_cmd_arith = 1'b1; end
            C_CMD_SUB: begin w_dp_ctl = C_ALU_SUB; w_cmd_arith = 1'b1; end
            C_CMD_AND: w_dp_ctl = C_ALU_AND;
            C_CMD_ORR: w_dp_ctl = C_ALU_ORR;
            C_CMD_EOR: w_dp_ctl = C_ALU_EOR;
            C_CMD_MOV: w_dp_ctl = C_ALU_MOV;
            C_CMD_CMP: begin
                w_dp_ctl    = C_ALU_SUB;
                w_cmd_arith = 1'b1;
                w_nowrite   = 1'b1;
            end
            default:   w_cmd_ok = 1'b0;   // unsupported: ADD, flags frozen
        endcase
    end

    // Flags only move in the execute states of an S-bit, passing, supported op
    assign w_flag_nz = ((r_state == S_EXECR) || (r_state == S_EXECI))
                       && w_funct[0] && w_cond_ex && w_cmd_ok;
    assign w_flag_cv = w_flag_nz && w_cmd_arith;

    cond_check u_cond (
        .clk         (clk),
        .reset       (reset),
        .i_cond      (w_cond),
        .i_alu_flags (ALUFlags),
        .i_wr_nz     (w_flag_nz),
        .i_wr_cv     (w_flag_cv),
        .o_cond_ex   (w_cond_ex),
        .o_flags     (w_flags)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // Next state and per-state outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = S_FETCH;
        w_pcwrite  = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_memwrite = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcB    = 2'b00;
        ImmSrc     = 2'b00;
        RegSrc     = 2'b00;
        ALUControl = C_ALU_ADD;
        case (r_state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = w_mem_ready;
                w_pcwrite = w_mem_ready;
                w_next    = w_mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (w_op)
                    C_OP_DP:  w_next = w_funct[5] ? S_EXECI : S_EXECR;
                    C_OP_MEM: w_next = S_MEMADR;
                    C_OP_BR:  w_next = S_BRANCH;
                    default:  w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB    = 2'b01;
                ImmSrc     = 2'b01;
                ALUControl = w_funct[3] ? C_ALU_ADD : C_ALU_SUB;  // U bit
                w_next     = w_funct[0] ? S_MEMRD : S_MEMWR;      // L bit
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                w_next = w_mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWR: begin
                AdrSrc     = 1'b1;
                RegSrc     = 2'b10;
                w_memwrite = w_cond_ex;
                w_next     = w_mem_ready ? S_FETCH : S_MEMWR;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = w_cond_ex;
                w_pcwrite  = w_cond_ex & w_rd_pc;
                w_next     = S_FETCH;
            end
            S_EXECR: begin
                ALUControl = w_dp_ctl;
                w_next     = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = w_dp_ctl;
                w_next     = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = w_cond_ex & ~w_nowrite;
                w_pcwrite  = w_cond_ex & ~w_nowrite & w_rd_pc;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ImmSrc    = 2'b10;
                RegSrc    = 2'b01;
                ResultSrc = 2'b10;
                w_pcwrite = w_cond_ex;
                w_next    = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Write strobes are forced low whenever reset is held
    assign PCWrite  = w_pcwrite  & reset;
    assign IRWrite  = w_irwrite  & reset;
    assign RegWrite = w_regwrite & reset;
    assign MemWrite = w_memwrite & reset;
    assign state_o  = r_state;

endmodule : multicycle_controller
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_controller
//  Description : Self-checking bench for multicycle_controller. Each cycle's
//                expected output vector is queued as stimulus is applied and
//                popped for comparison once the DUT outputs settle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic        clk;
    logic        reset;
    logic [19:0] Instr;
    logic [3:0]  ALUFlags;
    logic        mem_ready;
    logic        PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
    logic [1:0]  ResultSrc, ALUSrcB, ImmSrc, RegSrc;
    logic [3:0]  ALUControl, state_o;

    int errors = 0;
    int checks = 0;
    logic [21:0] exp_q[$];

    multicycle_controller #(.MEM_STALL(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ResultSrc  (ResultSrc),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .ALUControl (ALUControl),
        .state_o    (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector layout: state, PCW, IRW, RW, MW, AdrSrc, ALUSrcA, ResultSrc,
    // ALUSrcB, ImmSrc, RegSrc, ALUControl
    function automatic logic [21:0] ex(input logic [3:0] st, input logic pcw,
        input logic irw, input logic rw, input logic mw, input logic adr,
        input logic sa, input logic [1:0] res, input logic [1:0] sb,
        input logic [1:0] imm, input logic [1:0] rs, input logic [3:0] ctl);
        return {st, pcw, irw, rw, mw, adr, sa, res, sb, imm, rs, ctl};
    endfunction

    function automatic logic [21:0] e_fetch(input logic mr);
        return ex(4'd0, mr, mr, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 4'b0000);
    endfunction
    function automatic logic [21:0] e_decode();
        return ex(4'd1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 2'b00, 4'b0000);
    endfunction
    function automatic logic [21:0] e_memadr(input logic [3:0] ctl);
        return ex(4'd2, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, ctl);
    endfunction
    function automatic logic [21:0] e_memrd();
        return ex(4'd3, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
    endfunction
    function automatic logic [21:0] e_memwb(input logic rw, input logic pcw);
        return ex(4'd4, pcw, 0, rw, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000);
    endfunction
    function automatic logic [21:0] e_memwr(input logic mw);
        return ex(4'd5, 0, 0, 0, mw, 1, 0, 2'b00, 2'b00, 2'b00, 2'b10, 4'b0000);
    endfunction
    function automatic logic [21:0] e_execr(input logic [3:0] ctl);
        return ex(4'd6, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, ctl);
    endfunction
    function automatic logic [21:0] e_execi(input logic [3:0] ctl);
        return ex(4'd7, 0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 2'b00, ctl);
    endfunction
    function automatic logic [21:0] e_aluwb(input logic rw, input logic pcw);
        return ex(4'd8, pcw, 0, rw, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
    endfunction
    function automatic logic [21:0] e_branch(input logic pcw);
        return ex(4'd9, pcw, 0, 0, 0, 0, 0, 2'b10, 2'b01, 2'b10, 2'b01, 4'b0000);
    endfunction

    // One clock cycle: queue the expectation, drive inputs, compare settled outputs
    task automatic step(input string name, input logic [19:0] ins,
                        input logic [3:0] fl, input logic mr, input logic rn,
                        input logic [21:0] expv);
        logic [21:0] obs;
        logic [21:0] want;
        exp_q.push_back(expv);
        @(negedge clk);
        Instr     = ins;
        ALUFlags  = fl;
        mem_ready = mr;
        reset     = rn;
        #1;
        obs = {state_o, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA,
               ResultSrc, ALUSrcB, ImmSrc, RegSrc, ALUControl};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, observed %h", name, obs);
        end else begin
            want = exp_q.pop_front();
            if (obs !== want) begin
                errors++;
                $display("FAIL %s: outputs %h (state %0d) expected %h (state %0d)",
                         name, obs, obs[21:18], want, want[21:18]);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; Instr = '0; ALUFlags = '0; mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        // Held in reset: FETCH selects but no strobes even with mem_ready=1
        step("reset_hold", 20'h00000, 4'hF, 1'b1, 1'b0, e_fetch(1'b0));
        checks++;
        if (dut.w_flags !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: flags %b expected 0000", dut.w_flags);
        end
    endtask

    task automatic test_add();
        logic [19:0] i = 20'hE0811;
        step("add_fetch_stall", i, 4'hF, 1'b0, 1'b1, e_fetch(1'b0));
        step("add_fetch", i, 4'hF, 1'b1, 1'b1, e_fetch(1'b1));
        step("add_decode", i, 4'hF, 1'b1, 1'b1, e_decode());
        step("add_execr", i, 4'hF, 1'b1, 1'b1, e_execr(4'b0000));
        step("add_aluwb", i, 4'hF, 1'b1, 1'b1, e_aluwb(1'b1, 1'b0));
        checks++;
        if (dut.w_flags !== 4'b0000) begin
            errors++;
            $display("FAIL add_noflags: flags %b expected 0000", dut.w_flags);
        end
    endtask

    task automatic test_ldr_stall();
        logic [19:0] i = 20'hE5912;
        logic [19:0] p = 20'hE511F;
        step("ldr_fetch", i, 4'h0, 1'b1, 1'b1, e_fetch(1'b1));
        step("ldr_decode", i, 4'h0, 1'b1, 1'b1, e_decode());
        step("ldr_memadr", i, 4'h0, 1'b1, 1'b1, e_memadr(4'b0000));
        for (int k = 0; k < 3; k++)
            step("ldr_memrd_stall", i, 4'h0, 1'b0, 1'b1, e_memrd());
        step("ldr_memrd", i, 4'h0, 1'b1, 1'b1, e_memrd());
        step("ldr_memwb", i, 4'h0, 1'b1, 1'b1, e_memwb(1'b1, 1'b0));
        // LDR PC with U=0: subtract offset and write PC
        step("ldrpc_fetch", p, 4'h0, 1'b1, 1'b1, e_fetch(1'b1));
        step("ldrpc_decode", p, 4'h0, 1'b1, 1'b1, e_decode());
        step("ldrpc_memadr", p, 4'h0, 1'b1, 1'b1, e_memadr(4'b0001));
        step("ldrpc_memrd", p, 4'h0, 1'b1, 1'b1, e_memrd());
        step("ldrpc_memwb", p, 4'h0, 1'b1, 1'b1, e_memwb(1'b1, 1'b1));
    endtask

    task automatic test_condfail();
        // Flags are 0000 here, so EQ fails
        step("addeq_fetch", 20'h0080F, 4'h0, 1'b1, 1'b1, e_fetch(1'b1));
        step("addeq_decode", 20'h0080F, 4'h0, 1'b1, 1'b1, e_decode());
        step("addeq_execr", 20'h0080F, 4'h0, 1'b1, 1'b1, e_execr(4'b0000));
        step("addeq_aluwb", 20'h0080F, 4'h0, 1'b1, 1'b1, e_aluwb(1'b0, 1'b0));
        step("addpc_fetch", 20'hE080F, 4'h0, 1'b1, 1'b1, e_fetch(1'b1));
        step("addpc_decode", 20'hE080F, 4'h0, 1'b1, 1'b1, e_decode());
        step("addpc_execr", 20'hE080F, 4'h0, 1'b1, 1'b1, e_execr(4'b0000));
        step("addpc_aluwb", 20'hE080F, 4'h0, 1'b1, 1'b1, e_aluwb(1'b1, 1'b1));
        step("streq_fetch", 20'h05812, 4'h0, 1'b1, 1'b1, e_fetch(1'b1));
        step("streq_decode", 20'h05812, 4'h0, 1'b1, 1'b1, e_decode());
        step("streq_memadr", 20'h05812, 4'h0, 1'b1, 1'b1, e_memadr(4'b0000));
        step("streq_memwr", 20'h05812, 4'h0, 1'b1, 1'b1, e_memwr(1'b0));
        // SUBSEQ with failing condition must not touch the flags
        step("subseq_fetch", 20'h00511, 4'hF, 1'b1, 1'b1, e_fetch(1'b1));
        step("subseq_decode", 20'h00511, 4'hF, 1'b1, 1'b1, e_decode());
        step("subseq_execr", 20'h00511, 4'hF, 1'b1, 1'b1, e_execr(4'b0001));
        step("subseq_aluwb", 20'h00511, 4'hF, 1'b1, 1'b1, e_aluwb(1'b0, 1'b0));
        checks++;
        if (dut.w_flags !== 4'b0000) begin
            errors++;
            $display("FAIL condfail_flags: flags %b expected 0000", dut.w_flags);
        end
    endtask

    task automatic test_subs_branch();
        step("subs_fetch", 20'hE0511, 4'h4, 1'b1, 1'b1, e_fetch(1'b1));
        step("subs_decode", 20'hE0511, 4'h4, 1'b1, 1'b1, e_decode());
        step("subs_execr", 20'hE0511, 4'h4, 1'b1, 1'b1, e_execr(4'b0001));
        step("subs_aluwb", 20'hE0511, 4'h0, 1'b1, 1'b1, e_aluwb(1'b1, 1'b0));
        checks++;
        if (dut.w_flags !== 4'b0100) begin
            errors++;
            $display("FAIL subs_flags: flags %b expected 0100", dut.w_flags);
        end
        step("beq_fetch", 20'h0A000, 4'h0, 1'b1, 1'b1, e_fetch(1'b1));
        step("beq_decode", 20'h0A000, 4'h0, 1'b1, 1'b1, e_decode());
        step("beq_branch", 20'h0A000, 4'h0, 1'b1, 1'b1, e_branch(1'b1));
        step("bne_fetch", 20'h1A000, 4'h0, 1'b1, 1'b1, e_fetch(1'b1));
        step("bne_decode", 20'h1A000, 4'h0, 1'b1, 1'b1, e_decode());
        step("bne_branch", 20'h1A000, 4'h0, 1'b1, 1'b1, e_branch(1'b0));
    endtask

    task automatic test_cmp_logic();
        step("cmp_fetch", 20'hE3510, 4'hB, 1'b1, 1'b1, e_fetch(1'b1));
        step("cmp_decode", 20'hE3510, 4'hB, 1'b1, 1'b1, e_decode());
        step("cmp_execi", 20'hE3510, 4'hB, 1'b1, 1'b1, e_execi(4'b0001));
        step("cmp_aluwb", 20'hE3510, 4'h0, 1'b1, 1'b1, e_aluwb(1'b0, 1'b0));
        checks++;
        if (dut.w_flags !== 4'b1011) begin
            errors++;
            $display("FAIL cmp_flags: flags %b expected 1011", dut.w_flags);
        end
        // ANDS: N,Z from ALU, C,V keep previous 1,1
        step("ands_fetch", 20'hE0112, 4'h4, 1'b1, 1'b1, e_fetch(1'b1));
        step("ands_decode", 20'hE0112, 4'h4, 1'b1, 1'b1, e_decode());
        step("ands_execr", 20'hE0112, 4'h4, 1'b1, 1'b1, e_execr(4'b0010));
        step("ands_aluwb", 20'hE0112, 4'h0, 1'b1, 1'b1, e_aluwb(1'b1, 1'b0));
        checks++;
        if (dut.w_flags !== 4'b0111) begin
            errors++;
            $display("FAIL ands_flags: flags %b expected 0111", dut.w_flags);
        end
        // Unsupported cmd 0011 with S=1: ALUControl ADD, flags frozen
        step("rsbs_fetch", 20'hE0723, 4'h8, 1'b1, 1'b1, e_fetch(1'b1));
        step("rsbs_decode", 20'hE0723, 4'h8, 1'b1, 1'b1, e_decode());
        step("rsbs_execr", 20'hE0723, 4'h8, 1'b1, 1'b1, e_execr(4'b0000));
        step("rsbs_aluwb", 20'hE0723, 4'h8, 1'b1, 1'b1, e_aluwb(1'b1, 1'b0));
        checks++;
        if (dut.w_flags !== 4'b0111) begin
            errors++;
            $display("FAIL rsbs_flags: flags %b expected 0111", dut.w_flags);
        end
        // ORR via immediate and MOV via register for the decode table
        step("orr_fetch", 20'hE3812, 4'h0, 1'b1, 1'b1, e_fetch(1'b1));
        step("orr_decode", 20'hE3812, 4'h0, 1'b1, 1'b1, e_decode());
        step("orr_execi", 20'hE3812, 4'h0, 1'b1, 1'b1, e_execi(4'b0011));
        step("orr_aluwb", 20'hE3812, 4'h0, 1'b1, 1'b1, e_aluwb(1'b1, 1'b0));
        step("eor_fetch", 20'hE0212, 4'h0, 1'b1, 1'b1, e_fetch(1'b1));
        step("eor_decode", 20'hE0212, 4'h0, 1'b1, 1'b1, e_decode());
        step("eor_execr", 20'hE0212, 4'h0, 1'b1, 1'b1, e_execr(4'b0100));
        step("eor_aluwb", 20'hE0212, 4'h0, 1'b1, 1'b1, e_aluwb(1'b1, 1'b0));
        step("mov_fetch", 20'hE1A02, 4'h0, 1'b1, 1'b1, e_fetch(1'b1));
        step("mov_decode", 20'hE1A02, 4'h0, 1'b1, 1'b1, e_decode());
        step("mov_execr", 20'hE1A02, 4'h0, 1'b1, 1'b1, e_execr(4'b0101));
        step("mov_aluwb", 20'hE1A02, 4'h0, 1'b1, 1'b1, e_aluwb(1'b1, 1'b0));
    endtask

    task automatic test_op11();
        step("op11_fetch", 20'hEC000, 4'h0, 1'b1, 1'b1, e_fetch(1'b1));
        step("op11_decode", 20'hEC000, 4'h0, 1'b1, 1'b1, e_decode());
        step("op11_back", 20'hEC000, 4'h0, 1'b0, 1'b1, e_fetch(1'b0));
    endtask

    task automatic test_str_reset();
        logic [19:0] i = 20'hE5812;
        step("str_fetch", i, 4'h0, 1'b1, 1'b1, e_fetch(1'b1));
        step("str_decode", i, 4'h0, 1'b1, 1'b1, e_decode());
        step("str_memadr", i, 4'h0, 1'b1, 1'b1, e_memadr(4'b0000));
        step("str_memwr_stall0", i, 4'h0, 1'b0, 1'b1, e_memwr(1'b1));
        step("str_memwr_stall1", i, 4'h0, 1'b0, 1'b1, e_memwr(1'b1));
        step("str_memwr_reset", i, 4'h0, 1'b0, 1'b0, e_memwr(1'b0));
        step("str_after_reset", i, 4'h0, 1'b0, 1'b1, e_fetch(1'b0));
        checks++;
        if (dut.w_flags !== 4'b0000) begin
            errors++;
            $display("FAIL str_reset_flags: flags %b expected 0000", dut.w_flags);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldr_stall();
        test_condfail();
        test_subs_branch();
        test_cmp_logic();
        test_op11();
        test_str_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_multicycle_controller
`default_nettype wire
